uart_rx_ctrl: RTL and testbench

Receive control unit for the UART receiver. Detects the start bit on the serial line and times each bit to its midpoint. Issues one `shift_strobe` per bit to the 9-bit receive shift register (8 data + stop), checks the stop bit, and pulses `load_buffer` to capture the byte. Owns the `data_ready`, `framing_error` and `overrun_error` status seen by the consumer.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_bit_timer.sv | 47 ++++
 rtl/uart_rx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int FRAME_BITS = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        LOAD  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Cycle timer and strobe counter for the UART receiver; counts to mid start bit
// in half mode and to a full bit period otherwise.
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       half_mode,
    output logic       tick,
    output logic [3:0] bit_count
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_TERM = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_TERM = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    COUNT_MAX = 4'(FRAME_BITS);

    logic [TW-1:0] timer;

    assign tick = enable && (timer == (half_mode ? HALF_TERM : FULL_TERM));

    // NOTE: non-blocking assignments make every flop here sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            bit_count <= '0;
        end else if (clear) begin
            timer     <= '0;
            bit_count <= '0;
        end else if (enable) begin
            if (tick) begin
                timer <= '0;
                // Only full-period ticks are data strobes; the half tick confirms the start bit.
                if (!half_mode && bit_count != COUNT_MAX) begin
                    bit_count <= bit_count + 4'd1;
                end
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: line synchronizer, frame FSM, and consumer-facing
// ready/framing/overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic stop_bit,
    input  logic data_read,
    output logic line_sync,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic rx_busy
);

    rx_state_t  state;
    rx_state_t  state_next;
    logic       sync_meta;
    logic       line_prev;
    logic       tick;
    logic [3:0] bit_count;
    logic       start_edge;
    logic       last_bit;

    // Idle-high reset values keep the synchronizer from faking a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line_sync <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            line_sync <= sync_meta;
            line_prev <= line_sync;
        end
    end

    assign start_edge = line_prev && !line_sync;
    assign last_bit   = (bit_count == 4'(FRAME_BITS - 1));

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (state == START || state == DATA),
        .clear    (state == IDLE),
        .half_mode(state == START),
        .tick     (tick),
        .bit_count(bit_count)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = START;
            START:   if (tick) state_next = line_sync ? IDLE : DATA;
            DATA:    if (tick && last_bit) state_next = CHECK;
            CHECK:   state_next = stop_bit ? LOAD : IDLE;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign shift_strobe = (state == DATA) && tick;
    assign load_buffer  = (state == LOAD);
    assign rx_busy      = (state != IDLE);

    // A load coinciding with a read hands the new byte over cleanly: no overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (state == START && tick && !line_sync) begin
                framing_error <= 1'b0;
            end else if (state == CHECK && !stop_bit) begin
                framing_error <= 1'b1;
            end

            if (load_buffer) begin
                data_ready <= 1'b1;
            end else if (data_read) begin
                data_ready <= 1'b0;
            end

            if (load_buffer && data_ready && !data_read) begin
                overrun_error <= 1'b1;
            end else if (data_read) begin
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, glitch and
// mid-frame reset sequences, then randomized frames against a schedule model.
module tb_uart_rx_ctrl;

    localparam int CPB   = 10;
    localparam int HALF  = CPB / 2;
    localparam int NBITS = 9;
    localparam int NCYC  = 24000;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       read_before;
        logic       read_at_load;
        logic       exp_ready;
        logic       exp_fe;
        logic       exp_ovr;
        logic [7:0] exp_buf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic stop_bit;
    logic data_read = 1'b0;
    logic line_sync, shift_strobe, load_buffer, data_ready;
    logic framing_error, overrun_error, rx_busy;

    // Receive shift register and buffer that sit around the controller.
    logic [8:0] sr = '0;
    logic [7:0] rx_buf = '0;

    int cyc   = 2;
    int tests = 0;
    int fails = 0;

    // Expected-event schedule per cycle, filled in by the frame model.
    bit         exp_busy  [NCYC];
    bit         exp_strobe[NCYC];
    bit         exp_load  [NCYC];
    bit         fe_set    [NCYC];
    bit         fe_clr    [NCYC];
    bit         rd_at     [NCYC];
    bit         ser_hist  [NCYC];
    bit         rst_hist  [NCYC];
    logic [7:0] exp_byte  [NCYC];

    bit m_ready, m_ovr, m_fe;

    vec_t vecs[8];

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .stop_bit     (stop_bit),
        .data_read    (data_read),
        .line_sync    (line_sync),
        .shift_strobe (shift_strobe),
        .load_buffer  (load_buffer),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .rx_busy      (rx_busy)
    );

    initial forever #5 clk = ~clk;

    assign stop_bit = sr[8];

    always @(posedge clk) begin
        if (shift_strobe) sr <= {line_sync, sr[8:1]};
        if (load_buffer) rx_buf <= sr[7:0];
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {7'd0, act}, {7'd0, exp});
    endtask

    // Compare this cycle's outputs with the model, then advance the model flags.
    task automatic monitor();
        logic ls_e;
        ls_e = (rst_hist[cyc] || rst_hist[cyc-1] || rst_hist[cyc-2]) ? 1'b1 : ser_hist[cyc-2];
        check_bit("line_sync", line_sync, ls_e);
        check_bit("shift_strobe", shift_strobe, rst ? 1'b0 : exp_strobe[cyc]);
        check_bit("load_buffer", load_buffer, rst ? 1'b0 : exp_load[cyc]);
        check_bit("rx_busy", rx_busy, rst ? 1'b0 : exp_busy[cyc]);
        check_bit("data_ready", data_ready, rst ? 1'b0 : m_ready);
        check_bit("framing_error", framing_error, rst ? 1'b0 : m_fe);
        check_bit("overrun_error", overrun_error, rst ? 1'b0 : m_ovr);
        if (!rst && exp_load[cyc] && load_buffer) check("load_data", sr[7:0], exp_byte[cyc]);

        if (rst) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
            m_fe    = 1'b0;
        end else begin
            if (fe_clr[cyc]) m_fe = 1'b0;
            else if (fe_set[cyc]) m_fe = 1'b1;
            if (exp_load[cyc] && m_ready && !data_read) m_ovr = 1'b1;
            else if (data_read) m_ovr = 1'b0;
            if (exp_load[cyc]) m_ready = 1'b1;
            else if (data_read) m_ready = 1'b0;
        end
    endtask

    task automatic step();
        data_read     = rd_at[cyc];
        ser_hist[cyc] = serial_in;
        rst_hist[cyc] = rst;
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) step();
    endtask

    // Frame whose start bit is driven from cycle c: edge seen at c+2.
    task automatic sched_frame(input int c, input logic [7:0] d, input logic stop);
        int e;
        e = c + 2;
        for (int i = 1; i <= HALF + NBITS * CPB + (stop ? 2 : 1); i++) exp_busy[e+i] = 1'b1;
        for (int k = 1; k <= NBITS; k++) exp_strobe[e + HALF + k * CPB] = 1'b1;
        fe_clr[e + HALF] = 1'b1;
        if (stop) begin
            exp_load[e + HALF + NBITS * CPB + 2] = 1'b1;
            exp_byte[e + HALF + NBITS * CPB + 2] = d;
        end else begin
            fe_set[e + HALF + NBITS * CPB + 1] = 1'b1;
        end
    endtask

    task automatic drive_bits(input logic [7:0] d, input logic stop, input int nbits);
        logic v;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) v = 1'b0;
            else if (b == 9) v = stop;
            else v = d[b-1];
            serial_in = v;
            repeat (CPB) step();
        end
        serial_in = 1'b1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic read_at_load);
        sched_frame(cyc, d, stop);
        if (read_at_load) rd_at[cyc + 2 + HALF + NBITS * CPB + 2] = 1'b1;
        drive_bits(d, stop, 10);
    endtask

    task automatic send_glitch(input int len);
        int e;
        e = cyc + 2;
        for (int i = 1; i <= HALF; i++) exp_busy[e+i] = 1'b1;
        serial_in = 1'b0;
        repeat (len) step();
        serial_in = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h96};
        vecs[3] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7E};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

        @(posedge clk);
        #2;
        repeat (4) step();
        rst = 1'b0;
        idle(5);

        foreach (vecs[i]) begin
            if (vecs[i].read_before) rd_at[cyc+1] = 1'b1;
            idle(3);
            drive_frame(vecs[i].data, vecs[i].stop, vecs[i].read_at_load);
            idle(3);
            check_bit("vec_ready", data_ready, vecs[i].exp_ready);
            check_bit("vec_framing", framing_error, vecs[i].exp_fe);
            check_bit("vec_overrun", overrun_error, vecs[i].exp_ovr);
            check("vec_buffer", rx_buf, vecs[i].exp_buf);
        end

        // Start glitch: three low cycles must not start a frame.
        idle(5);
        send_glitch(3);
        idle(10);
        check_bit("glitch_idle", rx_busy, 1'b0);

        // Reset after the fourth strobe aborts the frame.
        sched_frame(cyc, 8'hC3, 1'b1);
        drive_bits(8'hC3, 1'b1, 5);
        rst = 1'b1;
        serial_in = 1'b1;
        for (int i = cyc; i < cyc + 150; i++) begin
            exp_busy[i]   = 1'b0;
            exp_strobe[i] = 1'b0;
            exp_load[i]   = 1'b0;
            fe_set[i]     = 1'b0;
            fe_clr[i]     = 1'b0;
        end
        #1;
        check_bit("rst_busy", rx_busy, 1'b0);
        check_bit("rst_ready", data_ready, 1'b0);
        check_bit("rst_line_sync", line_sync, 1'b1);
        repeat (3) step();
        rst = 1'b0;
        idle(5);
        drive_frame(8'h5A, 1'b1, 1'b0);
        idle(3);
        check("after_rst_buffer", rx_buf, 8'h5A);
        check_bit("after_rst_ready", data_ready, 1'b1);

        // Randomized frames, glitches and consumer reads.
        for (int n = 0; n < 120 && cyc < NCYC - 400; n++) begin
            int gap;
            gap = int'($urandom_range(2, 20));
            for (int i = 0; i < gap + 110; i++) begin
                if ($urandom_range(0, 40) == 0) rd_at[cyc+i] = 1'b1;
            end
            idle(gap);
            if ($urandom_range(0, 7) == 0) begin
                send_glitch(int'($urandom_range(1, 4)));
                idle(10);
            end else begin
                drive_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                            $urandom_range(0, 5) == 0);
            end
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
